// File: rtl/dmem_access_ctrl.sv
// Data-memory access controller for the MEM stage.
// Turns a load/store in MEM into one SRAM-style request/response transaction,
// places store data on the byte lanes, extends load data, and stalls the
// pipeline while the transaction is outstanding. A flush during a transaction
// lets the bus handshake finish but discards the result.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic [2:0]  load_store_mem,
  input  logic [31:0] addr_mem,
  input  logic [31:0] wdata_mem,
  input  logic        flush,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  output logic [3:0]  data_sram_wstrb,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata,
  output logic        addr_exc,
  output logic        stall_mem,
  output logic        rdata_valid,
  output logic [31:0] rdata_out
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    OP_LB  = 3'b000,
    OP_LBU = 3'b001,
    OP_LH  = 3'b010,
    OP_LHU = 3'b011,
    OP_LW  = 3'b100,
    OP_SB  = 3'b101,
    OP_SH  = 3'b110,
    OP_SW  = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10
  } size_e;

  state_e      state_q, state_d;
  logic        drop_q, drop_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  size_e       size_q, size_d;
  logic        wr_q, wr_d;
  logic [31:0] rdata_q, rdata_d;

  size_e       in_size;
  logic        in_store;
  logic [31:0] in_wdata;
  logic [3:0]  in_wstrb;
  logic        misalign;
  logic        accept;
  logic        resp_done;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Decode the incoming MEM-stage op: access size, direction and lane placement.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    in_size  = SZ_WORD;
    in_store = 1'b0;
    unique case (load_store_mem)
      OP_LB, OP_LBU: in_size = SZ_BYTE;
      OP_LH, OP_LHU: in_size = SZ_HALF;
      OP_LW:         in_size = SZ_WORD;
      OP_SB: begin
        in_size  = SZ_BYTE;
        in_store = 1'b1;
      end
      OP_SH: begin
        in_size  = SZ_HALF;
        in_store = 1'b1;
      end
      default: begin
        in_size  = SZ_WORD;
        in_store = 1'b1;
      end
    endcase

    in_wdata = wdata_mem;
    in_wstrb = 4'b1111;
    unique case (in_size)
      SZ_BYTE: begin
        in_wdata = {4{wdata_mem[7:0]}};
        in_wstrb = 4'b0001 << addr_mem[1:0];
      end
      SZ_HALF: begin
        in_wdata = {2{wdata_mem[15:0]}};
        in_wstrb = addr_mem[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        in_wdata = wdata_mem;
        in_wstrb = 4'b1111;
      end
    endcase
    if (!in_store) in_wstrb = 4'b0000;

    misalign = ((in_size == SZ_HALF) && addr_mem[0]) ||
               ((in_size == SZ_WORD) && (addr_mem[1:0] != 2'b00));
    accept   = mem_valid && (state_q == S_IDLE) && !misalign && !flush;
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      drop_q  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // Next-state logic; a flushed transaction still waits for data_ok, then skips DONE.
  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (flush) drop_d = 1'b1;
        if (data_sram_addr_ok) begin
          if (data_sram_data_ok) state_d = (drop_q || flush) ? S_IDLE : S_DONE;
          else                   state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (flush) drop_d = 1'b1;
        if (data_sram_data_ok) state_d = (drop_q || flush) ? S_IDLE : S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request fields are captured on acceptance and held for the whole transaction.
  always_comb begin
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    size_d  = size_q;
    wr_d    = wr_q;
    rdata_d = rdata_q;
    if (accept) begin
      op_d    = load_store_mem;
      addr_d  = addr_mem;
      wdata_d = in_wdata;
      wstrb_d = in_wstrb;
      size_d  = in_size;
      wr_d    = in_store;
    end
    resp_done = ((state_q == S_REQ) && data_sram_addr_ok && data_sram_data_ok) ||
                ((state_q == S_WAIT) && data_sram_data_ok);
    if (resp_done) rdata_d = data_sram_rdata;
  end

  // Latched request fields and returned read word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q    <= 3'b000;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      wstrb_q <= 4'b0000;
      size_q  <= SZ_BYTE;
      wr_q    <= 1'b0;
      rdata_q <= 32'h0;
    end else begin
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      size_q  <= size_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
    end
  end

  // FSM outputs: bus request, pipeline stall, exception and load-valid strobe.
  always_comb begin
    data_sram_req   = (state_q == S_REQ);
    data_sram_wr    = wr_q;
    data_sram_size  = size_q;
    data_sram_addr  = addr_q;
    data_sram_wdata = wdata_q;
    data_sram_wstrb = wstrb_q;
    addr_exc        = mem_valid && (state_q == S_IDLE) && misalign;
    stall_mem       = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    rdata_valid     = (state_q == S_DONE) && !wr_q && !flush;
  end

  // Select and extend the addressed byte/half of the returned word.
  always_comb begin
    unique case (addr_q[1:0])
      2'd0:    ld_byte = rdata_q[7:0];
      2'd1:    ld_byte = rdata_q[15:8];
      2'd2:    ld_byte = rdata_q[23:16];
      default: ld_byte = rdata_q[31:24];
    endcase
    ld_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];

    rdata_out = 32'h0;
    unique case (op_q)
      OP_LB:   rdata_out = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU:  rdata_out = {24'h0, ld_byte};
      OP_LH:   rdata_out = {{16{ld_half[15]}}, ld_half};
      OP_LHU:  rdata_out = {16'h0, ld_half};
      OP_LW:   rdata_out = rdata_q;
      default: rdata_out = 32'h0;
    endcase
  end

endmodule
